seg7_scan_ctrl: RTL
===================

Name: seg7_scan_ctrl

Overview:
- Drives a 4-digit multiplexed 7-segment display from one system clock.
- Holds a 16-bit hex word (4 nibbles) and sequences one digit per scan slot, with a blanking dead-time at the start of each slot to prevent ghosting.
- Software-side writes use a load/ready handshake; a new word is double-buffered and becomes visible only at a frame boundary, so the display never tears.
- Sits between the register/button logic and the board anode/segment pins; replaces the free-running divided scan clock with an in-domain slot counter.

Parameters:
- SYS_FREQ, 100000000, system clock frequency in Hz.
- SCAN_HZ, 1000, base per-digit slot rate in Hz, used when rate_sel=0.
- BLANK_CYCLES, 1000, clock cycles with all anodes off at the start of each slot.
- Derived constant BASE_SLOT = SYS_FREQ/SCAN_HZ, computed at elaboration; there is no runtime divider.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- data_in  in  16  hex word; [15:12] is digit 3 (leftmost, an[3]) and [3:0] is digit 0.
- dp_in  in  4  decimal points, bit i goes to digit i, 1 = lit.
- lz_en  in  1  leading-zero suppression enable.
- rate_sel  in  3  slot length = BASE_SLOT >> rate_sel.
- load  in  1  write request; accepted when load && ready.
- ready  out  1  pending buffer empty.
- an  out  4  anodes, active-low.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- frame_done  out  1  one-cycle pulse at the end of digit 3's slot.

Behaviour:
- Reset values: an=4'hF, seg=7'h7F, dp=1, ready=1, frame_done=0, digit index=0, slot counter=0, active word=0, active dp=0, pending buffer empty.
- Slot timing:
  - slot_len = max(BASE_SLOT >> rate_sel, BLANK_CYCLES+1).
  - rate_sel is sampled only when a slot starts, so a change mid-slot takes effect at the next slot.
- FSM states: BLANK, SHOW.
  - BLANK: an=4'hF, seg=7'h7F, dp=1. Lasts BLANK_CYCLES cycles (counter 0..BLANK_CYCLES-1), then goes to SHOW.
  - SHOW: the anode for the current digit index is driven low. Lasts slot_len-BLANK_CYCLES cycles. On the last cycle: index increments mod 4, the counter clears, and the FSM returns to BLANK.
- Frame end: the last SHOW cycle with index=3.
  - frame_done=1 on that cycle.
  - If the pending buffer is full, its contents move to the active registers on the same edge, the buffer clears, and ready returns to 1 on the next cycle.
- Handshake:
  - On load && ready, data_in and dp_in are captured into pending, and ready=0 from the next cycle.
  - load while ready=0 is ignored; there is no overwrite.
  - Load and frame end in the same cycle with the buffer empty: the word is captured into pending and shown from the following frame, never the current one.
- Outputs are registered. Segment/anode values change one cycle after the state/index change; an and seg always update on the same edge.
- Leading-zero suppression, when lz_en=1 and the slot is in SHOW:
  - digit 3 is blanked (seg=7'h7F) if nibble3=0;
  - digit 2 is blanked if nibbles 3 and 2 are 0;
  - digit 1 is blanked if nibbles 3 to 1 are 0;
  - digit 0 is never suppressed;
  - a suppressed digit's anode is still driven, and dp_in still applies.
- Hex decode: standard 0-F patterns, with b, d as lowercase glyphs.
- Reset asserted mid-slot or mid-handshake returns every register to its reset value on the next edge. The pending word is discarded.

Decomposition:
- Package seg7_pkg holds:
  - the state enum {BLANK, SHOW};
  - the 16-entry segment pattern constant array;
  - SEG_OFF = 7'h7F and AN_OFF = 4'hF.
- One combinational sub-module, hex_to_seg7 (4-bit in, 7-bit active-low out), is instantiated once on the muxed nibble.

Test Plan:
- All scenarios use SYS_FREQ=1000, SCAN_HZ=100, BLANK_CYCLES=2, so BASE_SLOT=10.
- Reset release, rate_sel=0: an=F for 2 cycles, then an=E for 8 cycles, then D, B, 7. frame_done pulses once every 40 cycles, aligned with the last cycle of an=7.
- load data_in=16'h12AF, dp_in=4'b0010 mid-frame: ready drops next cycle and the display is unchanged until frame end. In the next frame:
  - an=E shows seg for F;
  - an=D shows seg for A with dp=0;
  - an=B shows 2;
  - an=7 shows 1;
  - ready=1 again after the transfer.
- Second load while ready=0 (16'hFFFF): ignored; 16'h12AF remains displayed.
- lz_en=1, data_in=16'h0005: digits 3, 2, 1 show seg=7F with anodes still cycling; digit 0 shows 5. With data_in=16'h0000, only digit 0 shows 0.
- rate_sel=1 changed mid-slot: the current slot finishes at 10 cycles, later slots are 5 cycles. rate_sel=3 makes slot_len clamp to 3 (2 blank + 1 show).
- rst pulsed for 1 cycle during SHOW with the pending buffer full: the next cycle has an=F, seg=7F, ready=1, and the active word reads 0 (digit 0 shows 0 in its next SHOW).

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and constants for the 4-digit multiplexed 7-segment scanner.
package seg7_pkg;

    // Slot phases: anodes off for the dead-time, then one digit lit.
    typedef enum logic [0:0] {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    // All segments / all anodes off (both are active-low on the board).
    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Active-low {g,f,e,d,c,b,a} glyphs for 0-F; b and d are lowercase.
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Host-side write/config bus of the 7-segment scanner.
interface seg7_scan_ctrl_if;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic        lz_en;
    logic [2:0]  rate_sel;
    logic        load;
    logic        ready;

    // Register/button logic side.
    modport master (
        output data_in, dp_in, lz_en, rate_sel, load,
        input  ready
    );

    // Scanner side.
    modport slave (
        input  data_in, dp_in, lz_en, rate_sel, load,
        output ready
    );
endinterface

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment glyph decoder.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    assign seg = SEG_LUT[nibble];
endmodule

// File: rtl/seg7_scan_ctrl.sv
// 4-digit multiplexed 7-segment scanner with per-slot blanking dead-time,
// leading-zero suppression and a frame-aligned double-buffered word.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int SYS_FREQ     = 100000000,
    parameter int SCAN_HZ      = 1000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    seg7_scan_ctrl_if.slave      host,
    output logic [3:0]           an,
    output logic [6:0]           seg,
    output logic                 dp,
    output logic                 frame_done
);
    localparam int BASE_SLOT = SYS_FREQ / SCAN_HZ;
    localparam int MAX_LEN   = (BASE_SLOT > BLANK_CYCLES + 1) ? BASE_SLOT : BLANK_CYCLES + 1;
    localparam int CW        = $clog2(MAX_LEN + 1);

    state_t          state_reg;
    logic [CW-1:0]   cnt_reg;
    logic [CW-1:0]   slot_last_reg;
    logic [CW-1:0]   slot_last_next;
    logic [1:0]      idx_reg;
    logic [15:0]     word_reg;
    logic [3:0]      dp_act_reg;
    logic [15:0]     pend_word_reg;
    logic [3:0]      pend_dp_reg;
    logic            pend_full_reg;
    logic [31:0]     len_shifted;
    logic [31:0]     len_clamped;
    logic            show_last;
    logic            frame_end;
    logic            load_acc;
    logic [3:0]      nib [4];
    logic [3:0]      zero_above;
    logic [6:0]      dec_seg;

    // Slot length for the slot that is starting, clamped so SHOW is never empty.
    always_comb begin
        len_shifted    = 32'(BASE_SLOT) >> host.rate_sel;
        len_clamped    = (len_shifted > 32'(BLANK_CYCLES)) ? len_shifted : 32'(BLANK_CYCLES + 1);
        slot_last_next = CW'(len_clamped - 32'd1);
    end

    assign show_last  = (state_reg == SHOW) && (cnt_reg == slot_last_reg);
    assign frame_end  = show_last && (idx_reg == 2'd3);
    assign load_acc   = host.load && !pend_full_reg;
    assign host.ready = ~pend_full_reg;

    // Per-digit nibble slices and "this digit and everything left of it is zero".
    assign zero_above[0] = 1'b0;
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_nib
            assign nib[gi] = word_reg[4*gi +: 4];
        end
        for (genvar gi = 1; gi < 4; gi++) begin : g_lz
            assign zero_above[gi] = ~|word_reg[15:4*gi];
        end
    endgenerate

    hex_to_seg7 u_dec (
        .nibble (nib[idx_reg]),
        .seg    (dec_seg)
    );

    // Slot sequencer: blank dead-time, then show; rate_sel latched on the first blank cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= BLANK;
            cnt_reg       <= '0;
            idx_reg       <= 2'd0;
            slot_last_reg <= CW'(MAX_LEN - 1);
        end else begin
            case (state_reg)
                BLANK: begin
                    if (cnt_reg == '0)
                        slot_last_reg <= slot_last_next;
                    if (cnt_reg == CW'(BLANK_CYCLES - 1))
                        state_reg <= SHOW;
                    cnt_reg <= cnt_reg + CW'(1);
                end
                default: begin
                    if (show_last) begin
                        state_reg <= BLANK;
                        cnt_reg   <= '0;
                        idx_reg   <= idx_reg + 2'd1;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
            endcase
        end
    end

    // Pending buffer and frame-boundary transfer into the displayed word.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_reg      <= '0;
            dp_act_reg    <= '0;
            pend_word_reg <= '0;
            pend_dp_reg   <= '0;
            pend_full_reg <= 1'b0;
        end else begin
            if (frame_end && pend_full_reg) begin
                word_reg   <= pend_word_reg;
                dp_act_reg <= pend_dp_reg;
            end
            if (load_acc) begin
                pend_word_reg <= host.data_in;
                pend_dp_reg   <= host.dp_in;
                pend_full_reg <= 1'b1;
            end else if (frame_end) begin
                pend_full_reg <= 1'b0;
            end
        end
    end

    // Registered pin drive; anode and segments always move on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            if (state_reg == SHOW) begin
                an  <= ~(4'b0001 << idx_reg);
                seg <= (host.lz_en && zero_above[idx_reg]) ? SEG_OFF : dec_seg;
                dp  <= ~dp_act_reg[idx_reg];
            end else begin
                an  <= AN_OFF;
                seg <= SEG_OFF;
                dp  <= 1'b1;
            end
            frame_done <= frame_end;
        end
    end

endmodule
